// File: rtl/pll_lock_reset_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_reset_seq_pkg
// Description : Shared state encoding and clock constants for the PLL lock
//               qualifier / reset sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pll_lock_reset_seq_pkg;

  // Sequencer states; the encoding is exported on state_out.
  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_STABLE    = 2'd1,
    ST_HOLD      = 2'd2,
    ST_RUN       = 2'd3
  } state_t;

  // PLL output frequency feeding this block.
  localparam int unsigned c_pll_freq_hz = 12_500_000;

  // 12.5 MHz / 260 gives roughly a 48.08 kHz sample strobe.
  localparam int unsigned c_tick_div_default = 260;

endpackage
`default_nettype wire

// File: rtl/pll_lock_reset_seq_bit_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_sync
// Description : Generic N-stage single-bit synchronizer for asynchronous
//               status inputs, with synchronous active-high reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_lock_reset_seq.sv
`default_nettype none
// ============================================================================
// Module      : pll_lock_reset_seq
// Description : Qualifies the PLL lock indication, sequences the datapath
//               reset, generates the sample-rate strobe and counts lock-loss
//               events seen while running.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_lock_reset_seq
  import pll_lock_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int TICK_DIV      = int'(c_tick_div_default),
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked_in,
  output logic                  rst_out,
  output logic                  ready,
  output logic                  sample_tick,
  output logic [LOSS_CNT_W-1:0] lock_loss_count,
  output logic [1:0]            state_out
);

  // One phase counter is shared by STABLE and HOLD, sized for the longer one.
  localparam int c_cnt_max = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam int c_div_w   = $clog2(TICK_DIV);

  localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(STABLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_hold_last   = c_cnt_w'(HOLD_CYCLES - 1);
  localparam logic [c_div_w-1:0] c_div_last    = c_div_w'(TICK_DIV - 1);
  // Divider value one cycle before the strobe cycle; the strobe is registered.
  localparam logic [c_div_w-1:0] c_div_pre     = c_div_w'(TICK_DIV - 2);

  logic                  w_locked_s;
  state_t                r_state;
  logic [c_cnt_w-1:0]    r_cnt;
  logic [c_div_w-1:0]    r_div;
  logic                  r_rst_out;
  logic                  r_ready;
  logic                  r_tick;
  logic [LOSS_CNT_W-1:0] r_loss;

  bit_sync #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (locked_in),
    .o_sync  (w_locked_s)
  );

  // Sequencer FSM; every output is registered alongside the state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_WAIT_LOCK;
      r_cnt     <= '0;
      r_div     <= '0;
      r_rst_out <= 1'b1;
      r_ready   <= 1'b0;
      r_tick    <= 1'b0;
      r_loss    <= '0;
    end else begin
      case (r_state)
        ST_WAIT_LOCK: begin
          r_cnt <= '0;
          if (w_locked_s) begin
            r_state <= ST_STABLE;
          end
        end
        ST_STABLE: begin
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == c_stable_last) begin
            r_state <= ST_HOLD;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        ST_HOLD: begin
          if (!w_locked_s) begin
            r_state <= ST_WAIT_LOCK;
            r_cnt   <= '0;
          end else if (r_cnt == c_hold_last) begin
            r_state   <= ST_RUN;
            r_cnt     <= '0;
            r_div     <= '0;
            r_tick    <= 1'b0;
            r_rst_out <= 1'b0;
            r_ready   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        ST_RUN: begin
          if (!w_locked_s) begin
            // Lock lost while running: drop straight back into reset.
            r_state   <= ST_WAIT_LOCK;
            r_div     <= '0;
            r_tick    <= 1'b0;
            r_rst_out <= 1'b1;
            r_ready   <= 1'b0;
            if (r_loss != {LOSS_CNT_W{1'b1}}) begin
              r_loss <= r_loss + LOSS_CNT_W'(1);
            end
          end else begin
            r_div  <= (r_div == c_div_last) ? '0 : r_div + c_div_w'(1);
            r_tick <= (r_div == c_div_pre);
          end
        end
        default: begin
          r_state <= ST_WAIT_LOCK;
        end
      endcase
    end
  end

  assign rst_out         = r_rst_out;
  assign ready           = r_ready;
  assign sample_tick     = r_tick;
  assign lock_loss_count = r_loss;
  assign state_out       = r_state;

endmodule
`default_nettype wire

// File: doc/pll_lock_reset_seq.md
Name: pll_lock_reset_seq

Overview:
Sits directly downstream of the audio PLL and runs on its 12.5 MHz output clock. It qualifies the PLL lock indication and sequences a synchronous reset to the equalizer datapath. It also generates the audio sample-rate strobe and counts lock-loss events for software status.

Parameters:
SYNC_STAGES, 2, flops in the lock-input synchronizer (>=2)
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before hold phase (>=1)
HOLD_CYCLES, 16, extra cycles rst_out stays high after stable lock (>=1)
TICK_DIV, 260, clk cycles per sample_tick (12.5 MHz/260 ≈ 48.08 kHz) (>=2)
LOSS_CNT_W, 8, width of the lock-loss counter

Ports:
clk  in  1  PLL output clock (outclk_0, 12.5 MHz); the only clock
rst  in  1  synchronous active-high reset
locked_in  in  1  PLL locked; asynchronous to clk
rst_out  out  1  synchronous active-high reset to downstream datapath
ready  out  1  high only in RUN
sample_tick  out  1  one-cycle strobe every TICK_DIV cycles in RUN
lock_loss_count  out  LOSS_CNT_W  saturating count of RUN->lock-loss events
state_out  out  2  current state encoding: 0 WAIT_LOCK, 1 STABLE, 2 HOLD, 3 RUN

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising clk edge.
- rst=1 has priority over all other logic. Reset values: state WAIT_LOCK, rst_out=1, ready=0, sample_tick=0, lock_loss_count=0, synchronizer flops=0, all counters=0.
- locked_in passes through a SYNC_STAGES-flop synchronizer to produce locked_s. Only locked_s is used.
- All outputs are registered and update on the same edge as the state transition.
- WAIT_LOCK: cnt=0. If locked_s=1 -> STABLE with cnt=0.
- STABLE: if locked_s=0 -> WAIT_LOCK, cnt cleared, no loss count. Else if cnt==STABLE_CYCLES-1 -> HOLD with cnt=0. Else cnt++.
- HOLD: if locked_s=0 -> WAIT_LOCK, no loss count. Else if cnt==HOLD_CYCLES-1 -> RUN. Else cnt++.
- RUN: if locked_s=0 -> WAIT_LOCK, and lock_loss_count++ saturating at all-ones.
- rst_out=1 and ready=0 in every state except RUN. In RUN, rst_out=0 and ready=1.
- Latency: with locked_in held high, rst_out falls exactly SYNC_STAGES+1+STABLE_CYCLES+HOLD_CYCLES edges after the first edge that samples locked_in=1.
- Any drop of locked_s before RUN restarts qualification from WAIT_LOCK; a single-cycle drop is sufficient.
- Tick divider:
  - Cleared on the edge entering RUN; counts 0..TICK_DIV-1 and wraps to 0.
  - Let n be the RUN cycle index, with n=0 the first RUN cycle. sample_tick=1 in cycles where n mod TICK_DIV == TICK_DIV-1, so the first tick is in cycle TICK_DIV-1.
- On lock loss in RUN, on the same edge: sample_tick=0, divider cleared, rst_out=1, ready=0.
- Mid-operation rst: the whole sequence restarts from WAIT_LOCK and lock_loss_count clears.
- Counter widths: ceil(log2) of each limit. No wrap-around within a phase.

Decomposition:
- Shared package holds:
  - state encoding constants (WAIT_LOCK=0, STABLE=1, HOLD=2, RUN=3) and the state type;
  - the default TICK_DIV and the PLL-frequency constant 12.5 MHz.
- One sub-module: bit_sync, a generic N-stage single-bit synchronizer with synchronous active-high reset. It is reusable for other asynchronous status inputs.

Test Plan:
1. Bench parameters: SYNC_STAGES=2, STABLE_CYCLES=8, HOLD_CYCLES=4, TICK_DIV=5, LOSS_CNT_W=2. Run all scenarios with these values.
2. Hold rst for 3 cycles, then keep locked_in=0 for 50 cycles -> rst_out=1, ready=0, sample_tick=0, state_out=0 throughout.
3. Raise locked_in and hold it -> rst_out falls 15 edges after the first sampling edge. state_out passes 1 (8 cycles), 2 (4 cycles), 3. sample_tick pulses in RUN cycles 4, 9, 14.
4. Reach cycle 5 of STABLE, drop locked_in for 1 cycle, then hold high -> state_out returns to 0 and qualification restarts. rst_out never drops early. lock_loss_count stays 0.
5. From RUN, drop locked_in 4 separate times, re-locking each time -> lock_loss_count reads 1, 2, 3, 3 (saturated). rst_out=1 within SYNC_STAGES+1 edges of each drop.
6. From RUN with lock_loss_count=2, assert rst for 1 cycle while locked_in stays high -> all outputs return to reset values and lock_loss_count=0. rst_out falls again 15 edges after rst deasserts.
